// File: rtl/line_clear_detector_if.sv
// Bundles the line-clear detector's control, board-RAM and score signals.
// LINE_CLEAR_STATS_EN adds the cumulative total_lines output.
interface line_clear_detector_if #(
   parameter int unsigned COLS = 10,
   parameter int unsigned ROWS = 20,
   parameter int unsigned AW   = $clog2(ROWS)
);
   logic            start;
   logic [AW-1:0]   rd_addr;
   logic [COLS-1:0] rd_data;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [COLS-1:0] wr_data;
   logic            busy;
   logic            done;
   logic [2:0]      num_lines;
`ifdef LINE_CLEAR_STATS_EN
   logic [15:0]     total_lines;

   modport slave (
      input  start, rd_data,
      output rd_addr, wr_en, wr_addr, wr_data, busy, done, num_lines, total_lines
   );
   modport master (
      output start, rd_data,
      input  rd_addr, wr_en, wr_addr, wr_data, busy, done, num_lines, total_lines
   );
`else
   modport slave (
      input  start, rd_data,
      output rd_addr, wr_en, wr_addr, wr_data, busy, done, num_lines
   );
   modport master (
      output start, rd_data,
      input  rd_addr, wr_en, wr_addr, wr_data, busy, done, num_lines
   );
`endif
endinterface

// File: rtl/line_clear_detector.sv
// Finds full rows bottom-up, compacts the board in place and zero-fills the top rows.
// Define LINE_CLEAR_STATS_EN to add a saturating 16-bit cumulative cleared-row counter.
module line_clear_detector #(
   parameter int unsigned COLS = 10,
   parameter int unsigned ROWS = 20,
   localparam int unsigned AW  = $clog2(ROWS)
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   line_clear_detector_if.slave bus_io
);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StEval,
      StClear,
      StDone
   } state_e;

   localparam logic [AW-1:0] LastRow = AW'(ROWS - 1);
   localparam logic [AW-1:0] RowOne  = AW'(1);
   localparam logic [AW:0]   CntOne  = (AW+1)'(1);
   localparam logic [AW:0]   CntSat  = (AW+1)'(7);

   state_e        state_q, state_d;
   logic [AW-1:0] rd_row_q, rd_row_d;
   logic [AW-1:0] wr_row_q, wr_row_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          row_full;

   assign row_full = &bus_io.rd_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         rd_row_q <= '0;
         wr_row_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rd_row_q <= rd_row_d;
         wr_row_q <= wr_row_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      rd_row_d         = rd_row_q;
      wr_row_d         = wr_row_q;
      cnt_d            = cnt_q;
      bus_io.wr_en     = 1'b0;
      bus_io.wr_addr   = '0;
      bus_io.wr_data   = '0;
      bus_io.done      = 1'b0;
      bus_io.num_lines = 3'd0;

      unique case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               rd_row_d = LastRow;
               wr_row_d = LastRow;
               cnt_d    = '0;
               state_d  = StRead;
            end
         end

         StRead: begin
            state_d = StEval;
         end

         StEval: begin
            if (row_full) begin
               cnt_d = cnt_q + CntOne;
            end else begin
               // A row already in its final position needs no rewrite.
               if (rd_row_q != wr_row_q) begin
                  bus_io.wr_en   = 1'b1;
                  bus_io.wr_addr = wr_row_q;
                  bus_io.wr_data = bus_io.rd_data;
               end
               if (wr_row_q != '0) begin
                  wr_row_d = wr_row_q - RowOne;
               end
            end

            if (rd_row_q == '0) begin
               state_d = (cnt_d == '0) ? StDone : StClear;
            end else begin
               rd_row_d = rd_row_q - RowOne;
               state_d  = StRead;
            end
         end

         StClear: begin
            // wr_row enters at cnt-1, so counting it down to 0 gives exactly cnt writes.
            bus_io.wr_en   = 1'b1;
            bus_io.wr_addr = wr_row_q;
            bus_io.wr_data = '0;
            if (wr_row_q == '0) begin
               state_d = StDone;
            end else begin
               wr_row_d = wr_row_q - RowOne;
            end
         end

         StDone: begin
            bus_io.done      = 1'b1;
            bus_io.num_lines = (cnt_q > CntSat) ? 3'd7 : cnt_q[2:0];
            state_d          = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus_io.rd_addr = rd_row_q;
   assign bus_io.busy    = (state_q != StIdle);

`ifdef LINE_CLEAR_STATS_EN
   logic [15:0] total_q, total_d;
   logic [16:0] total_sum;

   assign total_sum = {1'b0, total_q} + 17'(cnt_q);

   always_comb begin
      total_d = total_q;
      if (state_q == StDone) begin
         total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign bus_io.total_lines = total_q;
`endif

   // Board writes only ever come from the compaction and zero-fill phases.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus_io.wr_en |-> (state_q inside {StEval, StClear}));

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus_io.num_lines != 3'd0) |-> bus_io.done);

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == StClear) |-> (cnt_q != '0));

endmodule

// File: doc/line_clear_detector.md
# line_clear_detector

Scans the playfield row memory after a piece locks and finds every completely filled row. Compacts the remaining rows downward in place and zero-fills the vacated top rows. Reports the number of cleared rows as a single-cycle `NUM_LINES` value, in the form `score_keeper` consumes on its `num_lines` input. Sits between the piece-lock logic and the board RAM on one side and `score_keeper` on the other.

## Interface
- `COLS`, 10, cells per row; one bit per cell, 1 = occupied
- `ROWS`, 20, rows on the board; row 0 is the top, row `ROWS-1` is the bottom
- `AW`, `$clog2(ROWS)`, row address width (derived; do not override)

- `CLK` in 1: system clock, 50 MHz
- `RESET_N` in 1: asynchronous, active-low reset
- `START` in 1: one-cycle request to run a scan; sampled only in IDLE
- `RD_ADDR` out AW: board RAM read row address
- `RD_DATA` in COLS: board RAM read data, valid exactly 1 cycle after `RD_ADDR`
- `WR_EN` out 1: board RAM write strobe
- `WR_ADDR` out AW: board RAM write row address
- `WR_DATA` out COLS: board RAM write data
- `BUSY` out 1: high from the cycle after `START` is accepted through the DONE cycle, inclusive
- `DONE` out 1: one-cycle completion pulse
- `NUM_LINES` out 3: cleared-row count; nonzero only during the DONE cycle, 0 at all other times

## Operation
- States: IDLE, READ, EVAL, CLEAR, DONE.
- **IDLE**
  - `START`=1 loads `rd_row`=`ROWS-1`, `wr_row`=`ROWS-1`, `cnt`=0, then goes to READ.
  - `START` in any other state is ignored.
- **READ:** drive `RD_ADDR`=`rd_row`, then go to EVAL.
- **EVAL** (`RD_DATA` valid):
  - Row full (all `COLS` bits 1): `cnt`++. No write.
  - Otherwise:
    - If `rd_row`≠`wr_row`, write `RD_DATA` to `wr_row`.
    - In both cases, `wr_row`--.
  - Next state:
    - `rd_row`=0 and `cnt`=0: DONE.
    - `rd_row`=0 and `cnt`>0: CLEAR.
    - Otherwise: `rd_row`--, then READ.
- **CLEAR:** write all-zero row to `wr_row`, `wr_row`--. Leave after exactly `cnt` writes (rows `cnt-1`..0), then go to DONE.
- **DONE**
  - `DONE`=1 and `NUM_LINES`=min(`cnt`,7), for one cycle.
  - Then go to IDLE.
- Arithmetic:
  - `cnt` is `AW+1` bits wide and cannot overflow (max `ROWS`).
  - `NUM_LINES` saturates at 3'd7. Legal play yields at most 4.
  - `wr_row` never decrements below 0. Its final value is don't-care.
- `WR_EN` is 0 in IDLE, READ and DONE.
- `WR_ADDR`/`WR_DATA` are don't-care when `WR_EN`=0.
- Reset mid-operation:
  - State goes to IDLE immediately (asynchronous).
  - `WR_EN`, `BUSY`, `DONE`, `NUM_LINES` go to 0 without waiting for a clock.
  - Board contents are left partially compacted. Recovery is the owner's responsibility.

## Timing
- Reset values: `RD_ADDR`=0, `WR_EN`=0, `WR_ADDR`=0, `WR_DATA`=0, `BUSY`=0, `DONE`=0, `NUM_LINES`=0, state IDLE.
- 2 cycles per row (READ, EVAL).
- With `n` full rows, and the first READ cycle numbered c1 (the cycle after the `START` edge):
  - EVAL for row r occurs at c1+2·(`ROWS-1`-r)+1.
  - CLEAR occupies c1+2·`ROWS` .. c1+2·`ROWS`+n-1.
  - DONE occurs at c1+2·`ROWS`+n (c1+40+n at defaults).
- `BUSY` falls the cycle after DONE. A new `START` is accepted in that cycle.
- Writes happen in EVAL or CLEAR cycles only, at most one per cycle.

## Configuration
- `LINE_CLEAR_STATS_EN` defined:
  - Adds output `TOTAL_LINES` (16 bits): cumulative cleared rows since reset.
  - Updated in the DONE cycle by adding `cnt`. Visible the following cycle.
  - Saturates at 16'hFFFF. Reset value 0.
- `LINE_CLEAR_STATS_EN` undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `RESET_N`=0 → all outputs 0, `BUSY`=0. Release, idle 10 cycles → no `WR_EN`, `NUM_LINES`=0 throughout.
- **No full rows:** board rows 0–19 each 10'h155, `START` → zero writes, `DONE` at c1+40, `NUM_LINES`=0 in that cycle only.
- **Single:** row 19=10'h3FF, row 18=10'h155, rows 0–17 random non-full, `START` → row r+1 ← old row r for r=0..18, row 0=0, `NUM_LINES`=1 at c1+41.
- **Tetris:** rows 16–19=10'h3FF, rows 0–15 distinct patterns → rows 4–19 hold old rows 0–15, rows 0–3=0, `NUM_LINES`=4 at c1+44. With `LINE_CLEAR_STATS_EN`, `TOTAL_LINES`=4 afterwards.
- **Gapped:** rows 17 and 19 full, row 18=10'h0F0 → row 19=10'h0F0, row 18 ← old row 16, rows 0–1=0, `NUM_LINES`=2.
- **Control edge cases:**
  - `START` pulsed at c1+5 → ignored, single DONE.
  - `RESET_N`=0 at c1+12 → `WR_EN`/`BUSY` drop before the next edge.
  - `START` after release → full scan completes normally.
